// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter shared by the load reservation station and the store buffer.
// Optional store-aging priority is enabled with `define DMEM_ARB_STORE_AGING_EN.
module dmem_arbiter #(
    parameter int ROB_DEPTH       = 3,
    parameter int STORE_AGE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_rqst,
    input  logic [31:0]          load_addr,
    input  logic [3:0]           load_rmask,
    input  logic [ROB_DEPTH-1:0] load_rob_idx,
    output logic                 load_grant,
    input  logic                 dmem_w_rqst,
    input  logic                 store_buffer_full,
    input  logic [3:0]           sb_wmask,
    input  logic [31:0]          sb_addr,
    input  logic [31:0]          sb_wdata,
    output logic                 store_buffer_pop,
    output logic [31:0]          dmem_addr,
    output logic [3:0]           dmem_rmask,
    output logic [3:0]           dmem_wmask,
    output logic [31:0]          dmem_wdata,
    input  logic [31:0]          dmem_rdata,
    input  logic                 dmem_resp,
    output logic                 load_resp_valid,
    output logic [31:0]          load_resp_rdata,
    output logic [ROB_DEPTH-1:0] load_resp_rob_idx,
    output logic [1:0]           state_dbg
);
    // Handshake: load_rqst is held until the single-cycle load_grant; store_buffer_pop and
    // load_resp_valid are single-cycle pulses; dmem_* stay stable from request until dmem_resp.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        LOAD  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           rmask_q, rmask_d;
    logic [3:0]           wmask_q, wmask_d;
    logic [ROB_DEPTH-1:0] tag_q, tag_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [31:0]          resp_rdata_q, resp_rdata_d;
    logic [ROB_DEPTH-1:0] resp_idx_q, resp_idx_d;
    logic                 store_pick;

`ifdef DMEM_ARB_STORE_AGING_EN
    localparam int AGE_W = $clog2(STORE_AGE_LIMIT + 1);
    logic [AGE_W-1:0] age_q, age_d;
    logic             age_hit;

    assign age_hit    = (age_q >= AGE_W'(STORE_AGE_LIMIT));
    assign store_pick = dmem_w_rqst && (store_buffer_full || !load_rqst || age_hit);
`else
    assign store_pick = dmem_w_rqst && (store_buffer_full || !load_rqst);
`endif

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        rmask_d          = rmask_q;
        wmask_d          = wmask_q;
        tag_d            = tag_q;
        resp_valid_d     = 1'b0;
        resp_rdata_d     = resp_rdata_q;
        resp_idx_d       = resp_idx_q;
        load_grant       = 1'b0;
        store_buffer_pop = 1'b0;
`ifdef DMEM_ARB_STORE_AGING_EN
        age_d            = age_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef DMEM_ARB_STORE_AGING_EN
                if (!dmem_w_rqst) age_d = '0;
`endif
                if (store_pick) begin
                    addr_d  = sb_addr;
                    wmask_d = sb_wmask;
                    wdata_d = sb_wdata;
                    rmask_d = 4'h0;
                    state_d = STORE;
`ifdef DMEM_ARB_STORE_AGING_EN
                    age_d   = '0;
`endif
                end else if (load_rqst) begin
                    load_grant = 1'b1;
                    addr_d     = load_addr;
                    rmask_d    = load_rmask;
                    wmask_d    = 4'h0;
                    wdata_d    = 32'h0;
                    tag_d      = load_rob_idx;
                    state_d    = LOAD;
`ifdef DMEM_ARB_STORE_AGING_EN
                    // Only loads that overtake a waiting store count toward its age.
                    if (dmem_w_rqst && !age_hit) age_d = age_q + AGE_W'(1);
`endif
                end
            end
            STORE: begin
                if (dmem_resp) begin
                    store_buffer_pop = 1'b1;
                    addr_d           = 32'h0;
                    wdata_d          = 32'h0;
                    rmask_d          = 4'h0;
                    wmask_d          = 4'h0;
                    state_d          = IDLE;
                end
            end
            LOAD: begin
                if (dmem_resp) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = dmem_rdata;
                    resp_idx_d   = tag_q;
                    addr_d       = 32'h0;
                    wdata_d      = 32'h0;
                    rmask_d      = 4'h0;
                    wmask_d      = 4'h0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            rmask_q      <= 4'h0;
            wmask_q      <= 4'h0;
            tag_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_idx_q   <= '0;
`ifdef DMEM_ARB_STORE_AGING_EN
            age_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rmask_q      <= rmask_d;
            wmask_q      <= wmask_d;
            tag_q        <= tag_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_idx_q   <= resp_idx_d;
`ifdef DMEM_ARB_STORE_AGING_EN
            age_q        <= age_d;
`endif
        end
    end

    assign dmem_addr         = addr_q;
    assign dmem_rmask        = rmask_q;
    assign dmem_wmask        = wmask_q;
    assign dmem_wdata        = wdata_q;
    assign load_resp_valid   = resp_valid_q;
    assign load_resp_rdata   = resp_rdata_q;
    assign load_resp_rob_idx = resp_idx_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a per-cycle vector table plus hand-written
// sequences for store/load payloads, priority, store aging and reset mid-store.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_rqst;
    logic [31:0] load_addr;
    logic [3:0]  load_rmask;
    logic [2:0]  load_rob_idx;
    logic        load_grant;
    logic        dmem_w_rqst;
    logic        store_buffer_full;
    logic [3:0]  sb_wmask;
    logic [31:0] sb_addr;
    logic [31:0] sb_wdata;
    logic        store_buffer_pop;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        load_resp_valid;
    logic [31:0] load_resp_rdata;
    logic [2:0]  load_resp_rob_idx;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ROB_DEPTH(3), .STORE_AGE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .load_rqst(load_rqst), .load_addr(load_addr), .load_rmask(load_rmask),
        .load_rob_idx(load_rob_idx), .load_grant(load_grant),
        .dmem_w_rqst(dmem_w_rqst), .store_buffer_full(store_buffer_full),
        .sb_wmask(sb_wmask), .sb_addr(sb_addr), .sb_wdata(sb_wdata),
        .store_buffer_pop(store_buffer_pop),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .load_resp_valid(load_resp_valid), .load_resp_rdata(load_resp_rdata),
        .load_resp_rob_idx(load_resp_rob_idx), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lr, wr, full, resp;
        logic       eg, ep, ev;
        logic [3:0] erm, ewm;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_rqst = 1'b0; dmem_w_rqst = 1'b0; store_buffer_full = 1'b0; dmem_resp = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    int n_grants;
    logic store_seen;

    initial begin
        rst = 1'b1;
        idle_inputs();
        load_addr = 32'h2004; load_rmask = 4'h3; load_rob_idx = 3'd5;
        sb_addr = 32'h1000; sb_wmask = 4'hF; sb_wdata = 32'hDEADBEEF;
        dmem_rdata = 32'h12345678;

        // lr wr full resp | grant pop valid rmask wmask
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'hF};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 4'h0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'hF};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};

        // Reset then idle
        tick();
        #1;
        chk("rst_rmask", {28'h0, dmem_rmask}, 32'h0);
        chk("rst_wmask", {28'h0, dmem_wmask}, 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_resp_rdata", load_resp_rdata, 32'h0);
        chk("rst_resp_idx", {29'h0, load_resp_rob_idx}, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_state", {30'h0, state_dbg}, 32'h0);
            chk("idle_masks", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
            chk("idle_pulses", {29'h0, load_grant, store_buffer_pop, load_resp_valid}, 32'h0);
            tick();
        end

        // Vector table: one row per cycle
        for (int i = 0; i < 15; i++) begin
            load_rqst = vecs[i].lr; dmem_w_rqst = vecs[i].wr;
            store_buffer_full = vecs[i].full; dmem_resp = vecs[i].resp;
            #1;
            chk($sformatf("vec%0d_grant", i), {31'h0, load_grant}, {31'h0, vecs[i].eg});
            chk($sformatf("vec%0d_pop", i), {31'h0, store_buffer_pop}, {31'h0, vecs[i].ep});
            chk($sformatf("vec%0d_valid", i), {31'h0, load_resp_valid}, {31'h0, vecs[i].ev});
            chk($sformatf("vec%0d_rmask", i), {28'h0, dmem_rmask}, {28'h0, vecs[i].erm});
            chk($sformatf("vec%0d_wmask", i), {28'h0, dmem_wmask}, {28'h0, vecs[i].ewm});
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_rdata", i), load_resp_rdata, 32'h12345678);
                chk($sformatf("vec%0d_idx", i), {29'h0, load_resp_rob_idx}, 32'd5);
            end
            tick();
        end
        idle_inputs();
        tick();

        // Single store with response three cycles after the request
        dmem_w_rqst = 1'b1;
        tick();
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                dmem_resp = 1'b1;
            end
            #1;
            chk("st_addr", dmem_addr, 32'h1000);
            chk("st_wmask", {28'h0, dmem_wmask}, 32'hF);
            chk("st_rmask", {28'h0, dmem_rmask}, 32'h0);
            chk("st_wdata", dmem_wdata, 32'hDEADBEEF);
            chk("st_pop", {31'h0, store_buffer_pop}, (c == 3) ? 32'd1 : 32'd0);
            tick();
        end
        idle_inputs();
        #1;
        chk("st_after_wmask", {28'h0, dmem_wmask}, 32'h0);
        chk("st_after_pop", {31'h0, store_buffer_pop}, 32'h0);
        tick();

        // Single load with distinct payload
        load_addr = 32'h2008; load_rmask = 4'hC; load_rob_idx = 3'd6; dmem_rdata = 32'hA5A50F0F;
        load_rqst = 1'b1;
        #1;
        chk("ld_grant", {31'h0, load_grant}, 32'd1);
        tick();
        load_rqst = 1'b0;
        dmem_resp = 1'b1;
        #1;
        chk("ld_grant_once", {31'h0, load_grant}, 32'd0);
        chk("ld_addr", dmem_addr, 32'h2008);
        chk("ld_rmask", {28'h0, dmem_rmask}, 32'hC);
        chk("ld_wdata", dmem_wdata, 32'h0);
        chk("ld_valid_early", {31'h0, load_resp_valid}, 32'd0);
        tick();
        dmem_resp = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        chk("ld_valid", {31'h0, load_resp_valid}, 32'd1);
        chk("ld_rdata", load_resp_rdata, 32'hA5A50F0F);
        chk("ld_idx", {29'h0, load_resp_rob_idx}, 32'd6);
        tick();
        #1;
        chk("ld_valid_once", {31'h0, load_resp_valid}, 32'd0);
        tick();

        // Full store buffer: store wins over a simultaneous load
        load_rqst = 1'b1; dmem_w_rqst = 1'b1; store_buffer_full = 1'b1;
        #1;
        chk("full_no_grant", {31'h0, load_grant}, 32'd0);
        tick();
        #1;
        chk("full_store_wmask", {28'h0, dmem_wmask}, 32'hF);
        chk("full_store_nogrant", {31'h0, load_grant}, 32'd0);
        dmem_resp = 1'b1;
        #1;
        chk("full_pop", {31'h0, store_buffer_pop}, 32'd1);
        tick();
        dmem_resp = 1'b0; dmem_w_rqst = 1'b0; store_buffer_full = 1'b0;
        #1;
        chk("full_then_grant", {31'h0, load_grant}, 32'd1);
        tick();
        load_rqst = 1'b0;
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        tick();

        // Store aging: continuous loads with a pending non-full store
        do_reset();
        n_grants = 0;
        store_seen = 1'b0;
        load_rqst = 1'b1; dmem_w_rqst = 1'b1;
        for (int g = 0; g < 12 && !store_seen; g++) begin
            #1;
            if (load_grant) begin
                n_grants++;
                tick();
                dmem_resp = 1'b1;
                tick();
                dmem_resp = 1'b0;
            end else begin
                tick();
                #1;
                if (dmem_wmask == 4'hF) store_seen = 1'b1;
                tick();
            end
        end
`ifdef DMEM_ARB_STORE_AGING_EN
        chk("age_load_grants", n_grants, 32'd8);
        chk("age_store_granted", {31'h0, store_seen}, 32'd1);
`else
        chk("noage_load_grants", n_grants, 32'd12);
        chk("noage_store_starved", {31'h0, store_seen}, 32'd0);
`endif
        do_reset();

        // Reset in the middle of a store
        dmem_w_rqst = 1'b1;
        tick();
        #1;
        chk("rst_mid_wmask_before", {28'h0, dmem_wmask}, 32'hF);
        rst = 1'b1;
        dmem_w_rqst = 1'b0;
        #1;
        chk("rst_mid_no_pop", {31'h0, store_buffer_pop}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_wmask_after", {28'h0, dmem_wmask}, 32'h0);
        chk("rst_mid_state", {30'h0, state_dbg}, 32'h0);
        dmem_w_rqst = 1'b1;
        tick();
        dmem_resp = 1'b1;
        #1;
        chk("rst_mid_retry_wmask", {28'h0, dmem_wmask}, 32'hF);
        chk("rst_mid_retry_pop", {31'h0, store_buffer_pop}, 32'd1);
        tick();
        idle_inputs();
        #1;
        chk("rst_mid_retry_clear", {28'h0, dmem_wmask}, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
